// File: rtl/waylookup_pkg.sv
// Shared constants, entry layout and waymask patch rule for the
// ICache way-lookup queue.
`define WAYLOOKUP_ENTRY_T(NP, SW, NW, TW) \
  struct packed { \
    logic [NP-1:0][SW-1:0] vset; \
    logic [NP-1:0][NW-1:0] way; \
    logic [NP-1:0][TW-1:0] ptag; \
    logic [NP-1:0][1:0]    exc; \
    logic [NP-1:0][1:0]    pbmt; \
    logic [NP-1:0]         meta; \
  }

package waylookup_pkg;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_PF   = 2'd1;
  localparam logic [1:0] EXC_GPF  = 2'd2;
  localparam logic [1:0] EXC_AF   = 2'd3;

  localparam int WAY_MAX = 64;

  // cur is the unpatched mask; prev carries the lower channels' result
  function automatic logic [WAY_MAX-1:0] update_waymask(
    input logic               set_hit,
    input logic               tag_hit,
    input logic               corrupt,
    input logic [WAY_MAX-1:0] cur,
    input logic [WAY_MAX-1:0] upd,
    input logic [WAY_MAX-1:0] prev
  );
    if (set_hit && tag_hit) return corrupt ? '0 : upd;
    if (set_hit && (cur == upd)) return '0;
    return prev;
  endfunction

endpackage

// File: rtl/waylookup_update.sv
// Patches one port's waymask against all refill update channels;
// the highest-index channel that applies decides the result.
module waylookup_update
  import waylookup_pkg::*;
#(
  parameter int NUM_WAYS   = 4,
  parameter int NUM_UPDATE = 1,
  parameter int SET_W      = 8,
  parameter int TAG_W      = 36,
  parameter int BLK_W      = 42
) (
  input  logic [SET_W-1:0]             vset_i,
  input  logic [TAG_W-1:0]             ptag_i,
  input  logic [NUM_WAYS-1:0]          way_i,
  input  logic [NUM_UPDATE-1:0]        upd_valid_i,
  input  logic [NUM_UPDATE*BLK_W-1:0]  upd_blk_i,
  input  logic [NUM_UPDATE*SET_W-1:0]  upd_set_i,
  input  logic [NUM_UPDATE*NUM_WAYS-1:0] upd_way_i,
  input  logic [NUM_UPDATE-1:0]        upd_corrupt_i,
  output logic [NUM_WAYS-1:0]          way_o
);

  logic [NUM_UPDATE-1:0] set_hit;
  logic [NUM_UPDATE-1:0] tag_hit;
  logic [WAY_MAX-1:0]    way_w;

  for (genvar c = 0; c < NUM_UPDATE; c++) begin : g_ch
    assign set_hit[c] = upd_valid_i[c] &&
      (upd_set_i[c*SET_W +: SET_W] == vset_i);
    assign tag_hit[c] =
      (upd_blk_i[c*BLK_W+BLK_W-1 -: TAG_W] == ptag_i);
  end

  always_comb begin
    way_w = WAY_MAX'(way_i);
    for (int c = 0; c < NUM_UPDATE; c++) begin
      way_w = update_waymask(
        set_hit[c], tag_hit[c], upd_corrupt_i[c],
        WAY_MAX'(way_i),
        WAY_MAX'(upd_way_i[c*NUM_WAYS +: NUM_WAYS]),
        way_w);
    end
  end

  assign way_o = way_w[NUM_WAYS-1:0];

  logic unused_bits;
  assign unused_bits = ^{way_w[WAY_MAX-1:NUM_WAYS], upd_blk_i};

endmodule

// File: rtl/way_lookup_queue.sv
// Way-lookup FIFO between ICache prefetch and main pipes, with
// in-place refill patching, empty bypass and one gpf side record.
module way_lookup_queue
  import waylookup_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_PORTS  = 2,
  parameter int NUM_UPDATE = 1,
  parameter int SET_W      = 8,
  parameter int TAG_W      = 36,
  parameter int BLK_W      = 42,
  parameter int GPADDR_W   = 56,
  parameter int BYPASS     = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic io_flush,
  input  logic io_write_valid,
  output logic io_write_ready,
  input  logic [NUM_PORTS*SET_W-1:0]    io_write_bits_entry_vSetIdx,
  input  logic [NUM_PORTS*NUM_WAYS-1:0] io_write_bits_entry_waymask,
  input  logic [NUM_PORTS*TAG_W-1:0]    io_write_bits_entry_ptag,
  input  logic [NUM_PORTS*2-1:0]        io_write_bits_entry_itlb_exception,
  input  logic [NUM_PORTS*2-1:0]        io_write_bits_entry_itlb_pbmt,
  input  logic [NUM_PORTS-1:0]          io_write_bits_entry_meta_codes,
  input  logic [GPADDR_W-1:0]           io_write_bits_gpf_gpaddr,
  input  logic                          io_write_bits_gpf_isForVSnonLeafPTE,
  output logic io_read_valid,
  input  logic io_read_ready,
  output logic [NUM_PORTS*SET_W-1:0]    io_read_bits_entry_vSetIdx,
  output logic [NUM_PORTS*NUM_WAYS-1:0] io_read_bits_entry_waymask,
  output logic [NUM_PORTS*TAG_W-1:0]    io_read_bits_entry_ptag,
  output logic [NUM_PORTS*2-1:0]        io_read_bits_entry_itlb_exception,
  output logic [NUM_PORTS*2-1:0]        io_read_bits_entry_itlb_pbmt,
  output logic [NUM_PORTS-1:0]          io_read_bits_entry_meta_codes,
  output logic [GPADDR_W-1:0]           io_read_bits_gpf_gpaddr,
  output logic                          io_read_bits_gpf_isForVSnonLeafPTE,
  input  logic [NUM_UPDATE-1:0]          io_update_valid,
  input  logic [NUM_UPDATE*BLK_W-1:0]    io_update_bits_blkPaddr,
  input  logic [NUM_UPDATE*SET_W-1:0]    io_update_bits_vSetIdx,
  input  logic [NUM_UPDATE*NUM_WAYS-1:0] io_update_bits_waymask,
  input  logic [NUM_UPDATE-1:0]          io_update_bits_corrupt,
  output logic [$clog2(DEPTH):0]         io_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef `WAYLOOKUP_ENTRY_T(NUM_PORTS, SET_W, NUM_WAYS, TAG_W) entry_t;

  entry_t mem_q   [DEPTH];
  entry_t mem_d   [DEPTH];
  entry_t mem_upd [DEPTH];
  entry_t wr_ent;
  entry_t wr_upd;
  entry_t rd_ent;

  logic [NUM_WAYS-1:0] mem_way [DEPTH][NUM_PORTS];
  logic [NUM_WAYS-1:0] wr_way  [NUM_PORTS];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        gpf_valid_q, gpf_valid_d;
  logic [AW:0] gpf_ptr_q, gpf_ptr_d;
  logic [GPADDR_W-1:0] gpf_addr_q, gpf_addr_d;
  logic        gpf_vs_q, gpf_vs_d;

  logic [NUM_UPDATE-1:0] upd_valid;
  logic ptr_empty, ptr_full, bypass, head_gpf;
  logic wr_gpf, rd_fire, wr_fire, enq, deq;

  // flush cycles must not patch storage
  assign upd_valid = io_update_valid & {NUM_UPDATE{~io_flush}};

  always_comb begin
    wr_ent.vset = io_write_bits_entry_vSetIdx;
    wr_ent.way  = io_write_bits_entry_waymask;
    wr_ent.ptag = io_write_bits_entry_ptag;
    wr_ent.exc  = io_write_bits_entry_itlb_exception;
    wr_ent.pbmt = io_write_bits_entry_itlb_pbmt;
    wr_ent.meta = io_write_bits_entry_meta_codes;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_wr
    waylookup_update #(
      .NUM_WAYS(NUM_WAYS), .NUM_UPDATE(NUM_UPDATE),
      .SET_W(SET_W), .TAG_W(TAG_W), .BLK_W(BLK_W)
    ) u_upd (
      .vset_i        (wr_ent.vset[p]),
      .ptag_i        (wr_ent.ptag[p]),
      .way_i         (wr_ent.way[p]),
      .upd_valid_i   (upd_valid),
      .upd_blk_i     (io_update_bits_blkPaddr),
      .upd_set_i     (io_update_bits_vSetIdx),
      .upd_way_i     (io_update_bits_waymask),
      .upd_corrupt_i (io_update_bits_corrupt),
      .way_o         (wr_way[p])
    );
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      waylookup_update #(
        .NUM_WAYS(NUM_WAYS), .NUM_UPDATE(NUM_UPDATE),
        .SET_W(SET_W), .TAG_W(TAG_W), .BLK_W(BLK_W)
      ) u_upd (
        .vset_i        (mem_q[i].vset[p]),
        .ptag_i        (mem_q[i].ptag[p]),
        .way_i         (mem_q[i].way[p]),
        .upd_valid_i   (upd_valid),
        .upd_blk_i     (io_update_bits_blkPaddr),
        .upd_set_i     (io_update_bits_vSetIdx),
        .upd_way_i     (io_update_bits_waymask),
        .upd_corrupt_i (io_update_bits_corrupt),
        .way_o         (mem_way[i][p])
      );
    end
  end

  always_comb begin
    wr_upd = wr_ent;
    for (int p = 0; p < NUM_PORTS; p++) wr_upd.way[p] = wr_way[p];
    for (int i = 0; i < DEPTH; i++) begin
      mem_upd[i] = mem_q[i];
      for (int p = 0; p < NUM_PORTS; p++)
        mem_upd[i].way[p] = mem_way[i][p];
    end
  end

  always_comb begin
    wr_gpf = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (wr_ent.exc[p] == EXC_GPF) wr_gpf = 1'b1;
  end

  assign ptr_empty = (wr_ptr_q == rd_ptr_q);
  assign ptr_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign bypass    = (BYPASS != 0) && ptr_empty && !io_flush;
  assign head_gpf  = gpf_valid_q && (gpf_ptr_q == rd_ptr_q);

  assign rd_ent = bypass ? wr_upd : mem_upd[rd_ptr_q[AW-1:0]];

  assign io_read_valid = !io_flush &&
                         (bypass ? io_write_valid : !ptr_empty);
  assign rd_fire = io_read_valid && io_read_ready;

  // a held gpf record blocks writes until its entry leaves
  assign io_write_ready = !ptr_full && !io_flush &&
                          (!gpf_valid_q || (rd_fire && head_gpf));
  assign wr_fire = io_write_valid && io_write_ready;

  assign enq = wr_fire && !(bypass && io_read_ready);
  assign deq = rd_fire && !bypass;

  assign io_read_bits_entry_vSetIdx        = rd_ent.vset;
  assign io_read_bits_entry_waymask        = rd_ent.way;
  assign io_read_bits_entry_ptag           = rd_ent.ptag;
  assign io_read_bits_entry_itlb_exception = rd_ent.exc;
  assign io_read_bits_entry_itlb_pbmt      = rd_ent.pbmt;
  assign io_read_bits_entry_meta_codes     = rd_ent.meta;
  assign io_count = count_q;

  always_comb begin
    io_read_bits_gpf_gpaddr            = '0;
    io_read_bits_gpf_isForVSnonLeafPTE = 1'b0;
    if (bypass) begin
      if (wr_gpf) begin
        io_read_bits_gpf_gpaddr = io_write_bits_gpf_gpaddr;
        io_read_bits_gpf_isForVSnonLeafPTE =
          io_write_bits_gpf_isForVSnonLeafPTE;
      end
    end else if (head_gpf) begin
      io_read_bits_gpf_gpaddr            = gpf_addr_q;
      io_read_bits_gpf_isForVSnonLeafPTE = gpf_vs_q;
    end
  end

  always_comb begin
    mem_d       = mem_upd;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    gpf_valid_d = gpf_valid_q;
    gpf_ptr_d   = gpf_ptr_q;
    gpf_addr_d  = gpf_addr_q;
    gpf_vs_d    = gpf_vs_q;
    if (io_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      gpf_valid_d = 1'b0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_upd;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
      if (deq && head_gpf) gpf_valid_d = 1'b0;
      if (enq && wr_gpf) begin
        gpf_valid_d = 1'b1;
        gpf_ptr_d   = wr_ptr_q;
        gpf_addr_d  = io_write_bits_gpf_gpaddr;
        gpf_vs_d    = io_write_bits_gpf_isForVSnonLeafPTE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gpf_valid_q <= 1'b0;
      gpf_ptr_q   <= '0;
      gpf_addr_q  <= '0;
      gpf_vs_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gpf_valid_q <= gpf_valid_d;
      gpf_ptr_q   <= gpf_ptr_d;
      gpf_addr_q  <= gpf_addr_d;
      gpf_vs_q    <= gpf_vs_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_way_lookup_queue.sv
// Randomised bench for way_lookup_queue against a queue-based
// reference model plus directed boundary scenarios.
module tb_way_lookup_queue;

  localparam int D  = 32;
  localparam int NU = 2;

  typedef struct packed {
    logic [1:0][7:0]  set;
    logic [1:0][3:0]  way;
    logic [1:0][35:0] tag;
    logic [1:0][1:0]  exc;
    logic [1:0][1:0]  pbmt;
    logic [1:0]       meta;
    logic             gpf;
    logic [55:0]      gaddr;
    logic             vs;
  } ment_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, flush, wv, rr;
  ment_t wr_m;
  logic [NU-1:0]        uv;
  logic [NU-1:0][41:0]  ublk;
  logic [NU-1:0][7:0]   uset;
  logic [NU-1:0][3:0]   uway;
  logic [NU-1:0]        ucor;

  logic        io_write_ready, io_read_valid;
  logic [15:0] io_read_bits_entry_vSetIdx;
  logic [7:0]  io_read_bits_entry_waymask;
  logic [71:0] io_read_bits_entry_ptag;
  logic [3:0]  io_read_bits_entry_itlb_exception;
  logic [3:0]  io_read_bits_entry_itlb_pbmt;
  logic [1:0]  io_read_bits_entry_meta_codes;
  logic [55:0] io_read_bits_gpf_gpaddr;
  logic        io_read_bits_gpf_isForVSnonLeafPTE;
  logic [5:0]  io_count;

  way_lookup_queue #(.DEPTH(D), .NUM_UPDATE(NU)) dut (
    .clock(clock),
    .reset(reset),
    .io_flush(flush),
    .io_write_valid(wv),
    .io_write_ready(io_write_ready),
    .io_write_bits_entry_vSetIdx(wr_m.set),
    .io_write_bits_entry_waymask(wr_m.way),
    .io_write_bits_entry_ptag(wr_m.tag),
    .io_write_bits_entry_itlb_exception(wr_m.exc),
    .io_write_bits_entry_itlb_pbmt(wr_m.pbmt),
    .io_write_bits_entry_meta_codes(wr_m.meta),
    .io_write_bits_gpf_gpaddr(wr_m.gaddr),
    .io_write_bits_gpf_isForVSnonLeafPTE(wr_m.vs),
    .io_read_valid(io_read_valid),
    .io_read_ready(rr),
    .io_read_bits_entry_vSetIdx(io_read_bits_entry_vSetIdx),
    .io_read_bits_entry_waymask(io_read_bits_entry_waymask),
    .io_read_bits_entry_ptag(io_read_bits_entry_ptag),
    .io_read_bits_entry_itlb_exception(io_read_bits_entry_itlb_exception),
    .io_read_bits_entry_itlb_pbmt(io_read_bits_entry_itlb_pbmt),
    .io_read_bits_entry_meta_codes(io_read_bits_entry_meta_codes),
    .io_read_bits_gpf_gpaddr(io_read_bits_gpf_gpaddr),
    .io_read_bits_gpf_isForVSnonLeafPTE(io_read_bits_gpf_isForVSnonLeafPTE),
    .io_update_valid(uv),
    .io_update_bits_blkPaddr(ublk),
    .io_update_bits_vSetIdx(uset),
    .io_update_bits_waymask(uway),
    .io_update_bits_corrupt(ucor),
    .io_count(io_count)
  );

  ment_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // refill rule: scan channels from the top, first that applies wins
  function automatic logic [3:0] patch(logic [7:0] s, logic [35:0] t,
                                       logic [3:0] w);
    if (flush) return w;
    for (int c = NU - 1; c >= 0; c--) begin
      if (uv[c] && uset[c] == s) begin
        if (ublk[c][41:6] == t) return ucor[c] ? 4'b0000 : uway[c];
        if (uway[c] == w) return 4'b0000;
      end
    end
    return w;
  endfunction

  task automatic cycle();
    ment_t h, e;
    logic erv, ewr, rf, wf, gh, byp;
    #1;
    byp = (q.size() == 0) && !flush;
    erv = !flush && (q.size() != 0 || wv);
    h = (q.size() != 0) ? q[0] : wr_m;
    for (int p = 0; p < 2; p++) h.way[p] = patch(h.set[p], h.tag[p], h.way[p]);
    gh = 1'b0;
    foreach (q[i]) if (q[i].gpf) gh = 1'b1;
    rf = erv && rr;
    ewr = !flush && (q.size() < D) &&
          (!gh || (rf && q.size() != 0 && q[0].gpf));
    wf = wv && ewr;
    check("read_valid", io_read_valid, erv);
    check("write_ready", io_write_ready, ewr);
    check("count", io_count, q.size());
    if (erv) begin
      check("vset", io_read_bits_entry_vSetIdx, h.set);
      check("waymask", io_read_bits_entry_waymask, h.way);
      check("ptag", io_read_bits_entry_ptag, h.tag);
      check("exc", io_read_bits_entry_itlb_exception, h.exc);
      check("pbmt", io_read_bits_entry_itlb_pbmt, h.pbmt);
      check("meta", io_read_bits_entry_meta_codes, h.meta);
      check("gpaddr", io_read_bits_gpf_gpaddr, h.gpf ? h.gaddr : 56'h0);
      check("gpf_vs", io_read_bits_gpf_isForVSnonLeafPTE, h.gpf & h.vs);
    end
    @(posedge clock);
    if (flush) q.delete();
    else begin
      foreach (q[i]) begin
        e = q[i];
        for (int p = 0; p < 2; p++)
          e.way[p] = patch(e.set[p], e.tag[p], e.way[p]);
        q[i] = e;
      end
      if (rf && !byp) void'(q.pop_front());
      if (wf && !(byp && rf)) begin
        e = wr_m;
        for (int p = 0; p < 2; p++)
          e.way[p] = patch(e.set[p], e.tag[p], e.way[p]);
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic set_wr(input logic [7:0] s, input logic [35:0] t,
                        input logic [3:0] w, input logic [1:0] ex,
                        input logic [55:0] ga);
    wr_m.set  = {8'h55, s};
    wr_m.tag  = {36'h77, t};
    wr_m.way  = {4'b0001, w};
    wr_m.exc  = {2'd0, ex};
    wr_m.pbmt = 4'b0110;
    wr_m.meta = 2'b01;
    wr_m.gaddr = ga;
    wr_m.vs   = 1'b1;
    wr_m.gpf  = (ex == 2'd2);
  endtask

  task automatic rand_wr();
    int v;
    for (int p = 0; p < 2; p++) begin
      wr_m.set[p] = 8'h10 + 8'($urandom % 2);
      wr_m.tag[p] = 36'hA + 36'($urandom % 2);
      wr_m.way[p] = 4'($urandom);
      v = $urandom % 3;
      wr_m.exc[p] = ($urandom % 12 == 0) ? 2'd2 : (v == 2 ? 2'd3 : 2'(v));
      wr_m.pbmt[p] = 2'($urandom);
    end
    wr_m.meta  = 2'($urandom);
    wr_m.gaddr = 56'({$urandom(), $urandom()});
    wr_m.vs    = 1'($urandom);
    wr_m.gpf   = (wr_m.exc[0] == 2'd2) || (wr_m.exc[1] == 2'd2);
  endtask

  task automatic clr_upd();
    uv = '0; ublk = '0; uset = '0; uway = '0; ucor = '0;
  endtask

  task automatic set_upd(input int c, input logic [7:0] s,
                         input logic [35:0] t, input logic [3:0] w,
                         input logic cor);
    uv[c] = 1'b1;
    uset[c] = s;
    ublk[c] = {t, 6'h15};
    uway[c] = w;
    ucor[c] = cor;
  endtask

  task automatic rand_upd();
    for (int c = 0; c < NU; c++) begin
      uv[c]   = ($urandom % 3 == 0);
      uset[c] = 8'h10 + 8'($urandom % 2);
      ublk[c] = {36'hA + 36'($urandom % 2), 6'($urandom)};
      uway[c] = 4'b0001 << ($urandom % 4);
      ucor[c] = ($urandom % 4 == 0);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wv = 1'b0; rr = 1'b0;
    clr_upd();
    set_wr(8'h0, 36'h0, 4'h0, 2'd0, 56'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    cycle();

    // fill to full, then drain in order
    for (int i = 0; i < D; i++) begin
      set_wr(8'(i), 36'(i * 3), 4'(i), 2'd0, 56'h0);
      wv = 1'b1; rr = 1'b0;
      cycle();
    end
    #1;
    check("full_count", io_count, 32);
    check("full_wready", io_write_ready, 1'b0);
    cycle();
    wv = 1'b0; rr = 1'b1;
    for (int i = 0; i < D; i++) cycle();
    #1;
    check("drained_rvalid", io_read_valid, 1'b0);
    cycle();

    // bypass on empty queue
    set_wr(8'h01, 36'h123, 4'b0100, 2'd0, 56'h0);
    wv = 1'b1; rr = 1'b1;
    #1;
    check("byp_ptag", io_read_bits_entry_ptag[35:0], 36'h123);
    cycle();
    wv = 1'b0; rr = 1'b0;
    cycle();

    // tag hit patch, then corrupt
    for (int k = 0; k < 2; k++) begin
      set_wr(8'h10, 36'hA, 4'b0010, 2'd0, 56'h0);
      wv = 1'b1; rr = 1'b0;
      cycle();
      wv = 1'b0; rr = 1'b1;
      set_upd(0, 8'h10, 36'hA, 4'b1000, 1'(k));
      #1;
      check("hit_way", io_read_bits_entry_waymask[3:0],
            k == 0 ? 4'b1000 : 4'b0000);
      cycle();
      clr_upd();
    end

    // eviction by matching waymask on tag mismatch
    set_wr(8'h10, 36'hB, 4'b0100, 2'd0, 56'h0);
    wv = 1'b1; rr = 1'b0;
    cycle();
    wv = 1'b0; rr = 1'b1;
    set_upd(0, 8'h10, 36'hA, 4'b0100, 1'b0);
    #1;
    check("evict_way", io_read_bits_entry_waymask[3:0], 4'b0000);
    cycle();
    clr_upd();

    // two channels on one entry: channel 1 wins
    set_wr(8'h10, 36'hA, 4'b0010, 2'd0, 56'h0);
    wv = 1'b1; rr = 1'b0;
    cycle();
    wv = 1'b0; rr = 1'b1;
    set_upd(0, 8'h10, 36'hA, 4'b1000, 1'b0);
    set_upd(1, 8'h10, 36'hA, 4'b0001, 1'b0);
    #1;
    check("dual_way", io_read_bits_entry_waymask[3:0], 4'b0001);
    cycle();
    clr_upd();

    // gpf entry behind three normal ones
    rr = 1'b0; wv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_wr(8'h20 + 8'(i), 36'h40 + 36'(i), 4'b0001, 2'd0, 56'h0);
      cycle();
    end
    set_wr(8'h30, 36'h50, 4'b0010, 2'd2, 56'hDEAD);
    cycle();
    set_wr(8'h31, 36'h51, 4'b0100, 2'd0, 56'h0);
    #1;
    check("gpf_block", io_write_ready, 1'b0);
    cycle();
    rr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("gpf_head", io_read_bits_gpf_gpaddr,
            i == 3 ? 56'hDEAD : 56'h0);
      if (i == 3) check("gpf_release", io_write_ready, 1'b1);
      cycle();
    end
    wv = 1'b0;
    repeat (2) cycle();

    // flush with entries and a held gpf record
    rr = 1'b0; wv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_wr(8'h40 + 8'(i), 36'h60 + 36'(i), 4'b1000,
             i == 4 ? 2'd2 : 2'd0, 56'hBEEF);
      cycle();
    end
    flush = 1'b1; rr = 1'b1;
    cycle();
    flush = 1'b0; wv = 1'b0; rr = 1'b0;
    #1;
    check("flush_rvalid", io_read_valid, 1'b0);
    check("flush_count", io_count, 0);
    cycle();
    set_wr(8'h20, 36'h321, 4'b1000, 2'd0, 56'h0);
    wv = 1'b1;
    cycle();
    wv = 1'b0; rr = 1'b1;
    #1;
    check("post_flush_ptag", io_read_bits_entry_ptag[35:0], 36'h321);
    cycle();

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      wv = ($urandom % 4 != 0);
      rr = ($urandom % 2 == 0);
      flush = ($urandom % 64 == 0);
      rand_wr();
      rand_upd();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/way_lookup_queue.md
# way_lookup_queue

Parametrised way-lookup FIFO between the ICache prefetch pipe (producer) and main pipe (consumer). Each entry carries per-fetch-port set index, hit waymask, physical tag, ITLB exception/PBMT and meta parity code. A single guest-page-fault side record travels with at most one entry. Queued waymasks are patched in place by N concurrent refill update channels. Relative to the fixed 2-port, single-update queue it generalises depth, way count, port count and update channel count, and adds an optional empty bypass and an occupancy output.

## Interface
- DEPTH, 32: entries, power of two, ≥2
- NUM_WAYS, 4: waymask width
- NUM_PORTS, 2: fetch ports per entry
- NUM_UPDATE, 1: refill update channels, ≥1
- SET_W, 8: vSetIdx width
- TAG_W, 36: ptag width
- BLK_W, 42: update blkPaddr width; tag = blkPaddr[BLK_W-1 -: TAG_W]
- GPADDR_W, 56: gpf gpaddr width
- BYPASS, 1: enable empty-queue pass-through
- clock in 1: sole clock
- reset in 1: synchronous, active-high
- io_flush in 1: drop all entries and gpf record
- io_write_valid in 1 / io_write_ready out 1: producer handshake
- io_write_bits_entry_{vSetIdx,waymask,ptag,itlb_exception,itlb_pbmt,meta_codes} in NUM_PORTS×{SET_W,NUM_WAYS,TAG_W,2,2,1}: packed, port 0 in LSBs
- io_write_bits_gpf_gpaddr in GPADDR_W; io_write_bits_gpf_isForVSnonLeafPTE in 1
- io_read_valid out 1 / io_read_ready in 1; io_read_bits_* out: mirror of write bits
- io_update_valid in NUM_UPDATE; io_update_bits_{blkPaddr,vSetIdx,waymask,corrupt} in NUM_UPDATE×{BLK_W,SET_W,NUM_WAYS,1}
- io_count out $clog2(DEPTH)+1: stored entries

## Operation
- Circular buffer, read/write pointers with extra wrap bit; empty = pointers equal, full = indices equal and wrap bits differ.
- Write fire = write_valid & write_ready. Read fire = read_valid & read_ready.
- Update, per entry and port, channels evaluated in index order, highest index wins:
  - set match and tag match: waymask := corrupt ? 0 : update waymask.
  - set match, tag mismatch, stored waymask == update waymask: waymask := 0 (way evicted).
  - Otherwise unchanged.
  - Update also applies to the write-in entry in the same cycle and to bypass data.
- Bypass (BYPASS=1, empty, no flush): read_valid = write_valid. Read bits = updated write bits. If read_ready, the entry is not enqueued. With BYPASS=0 an empty queue gives read_valid=0.
- GPF record:
  - Captured on a write fire where any port itlb_exception == 2'd2. Stores gpaddr, isForVSnonLeafPTE and the entry's pointer.
  - Read gpf outputs equal the record only when the head (or bypassed entry) is the gpf entry; otherwise 0.
  - Record cleared when that entry is read.
  - While a record is held and not being read this cycle, write_ready=0.
- write_ready = !full & !flush & gpf rule. Write while full is refused. A simultaneous read and write when full still refuses the write.

## Timing
- Reset and flush: pointers 0, gpf cleared, io_count=0, read_valid=0, write_ready=1 the following cycle.
- Flush cycle: read_valid=0, write_ready=0, and updates are ignored.
- Write-to-read latency is 1 cycle via storage, 0 via bypass.
- Update takes effect on storage the cycle after update_valid. A read in the same cycle as an update sees the patched waymask (combinational forward).
- io_count is registered and reflects fires from the prior cycle.
- Pointer wrap at DEPTH-1→0 toggles the wrap bit.

## Structure
- Package waylookup_pkg:
  - EXC_GPF=2'd2 and the remaining exception codes.
  - Entry struct typedef parameterised through macros.
  - update_waymask function.
- One sub-module, waylookup_update, holds the per-port waymask patch logic. It is instantiated DEPTH×NUM_PORTS times, plus once per port for the write/bypass path.

## Test plan
- Write 32 entries without reads (DEPTH=32) → write_ready=0 after the 32nd and io_count=32. Read all 32 → in-order data, then read_valid=0.
- Empty queue, BYPASS=1, write and read in the same cycle with ptag 0x123 → read ptag 0x123 in that cycle, io_count stays 0.
- Queue entry with vSetIdx 0x10, ptag 0xA, waymask 4'b0010. Issue update with blkPaddr tag 0xA, set 0x10, waymask 4'b1000 → read waymask 4'b1000. Same update with corrupt=1 → 4'b0000.
- Entry with set 0x10, tag 0xB, waymask 4'b0100. Update with tag 0xA, waymask 4'b0100 → read waymask 0. Two channels hitting the same entry in the same cycle → channel 1 value.
- Write gpf entry (exception 2, gpaddr 0xDEAD) behind 3 normal entries → write_ready=0. Gpf outputs are 0 for the first 3 reads and 0xDEAD on the 4th, then write_ready=1.
- Flush with 5 entries queued and a gpf record held → read_valid=0 and io_count=0 next cycle. Next write is accepted and read back correctly.
